avr_sram_master: RTL

- Host-side initiator for the CPLD SRAM bridge; acts as the transmitter end of the serial-address / parallel-data interface.
- Accepts parallel read/write requests (21-bit address, 8-bit data) from a local controller.
- Serialises the address MSB-first onto a shift clock/data pair, then sequences the active-low SRAM strobes (ce/oe/we) across the bridge.
- Drives write data onto, or captures read data from, the shared 8-bit bus.
- Used in the FPGA host build and as the driver model for bridge bring-up.

---
 rtl/avr_sram_master_pkg.sv | 35 +++
 rtl/avr_sram_master_addr_serializer.sv | 86 ++++++++
 rtl/avr_sram_master.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/avr_sram_master_pkg.sv
// ---------------------------------------------------------------------------
// avr_sram_master_pkg
// Shared definitions for the host-side SRAM bridge initiator:
//   - ADDR_W_DEF / DATA_W_DEF : default address / data widths (the bridge
//                               shift register uses the same address width)
//   - state_t                 : transaction sequencer state encoding
//   - txn_latency()           : cycles from the accepting edge to the cycle in
//                               which rsp_valid is high
// ---------------------------------------------------------------------------
package avr_sram_master_pkg;

    localparam int ADDR_W_DEF = 21;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    // A full transaction spends 2*clk_div cycles per address bit, then one
    // SETUP cycle, strobe_cyc STROBE cycles and the HOLD cycle.
    function automatic int unsigned txn_latency(input int unsigned addr_w,
                                                input int unsigned clk_div,
                                                input int unsigned strobe_cyc,
                                                input logic        shift_skipped);
        if (shift_skipped)
            return strobe_cyc + 2;
        return 2 * clk_div * addr_w + strobe_cyc + 2;
    endfunction

endpackage

// File: rtl/avr_sram_master_addr_serializer.sv
// ---------------------------------------------------------------------------
// avr_addr_serializer
// Shifts an address MSB-first onto the sreg_clk / sreg_si pair. Each bit gets
// CLK_DIV cycles with sreg_clk low (sreg_si changes on entry to this phase)
// followed by CLK_DIV cycles with sreg_clk high, so exactly ADDR_W rising
// edges are produced per start.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle pulse, loads addr and begins shifting
//   addr       : address to shift (sampled on start)
//   half_end   : high in the last cycle of every half period
//   done       : high in the last cycle of the final high phase
//   sreg_clk   : registered shift clock
//   sreg_si    : registered shift data
// ---------------------------------------------------------------------------
module avr_addr_serializer
    import avr_sram_master_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic              half_end,
    output logic              done,
    output logic              sreg_clk,
    output logic              sreg_si
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(ADDR_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(ADDR_W - 1);

    logic              active_reg;
    logic [DW-1:0]     div_cnt_reg;
    logic [BW-1:0]     bit_cnt_reg;
    // Holds the bits still to be sent; the MSB goes straight to sreg_si.
    logic [ADDR_W-2:0] shreg_reg;
    logic              sreg_clk_reg;
    logic              sreg_si_reg;

    assign half_end = active_reg && (div_cnt_reg == DIV_LAST);
    assign done     = half_end && sreg_clk_reg && (bit_cnt_reg == '0);
    assign sreg_clk = sreg_clk_reg;
    assign sreg_si  = sreg_si_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_reg   <= 1'b0;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            shreg_reg    <= '0;
            sreg_clk_reg <= 1'b0;
            sreg_si_reg  <= 1'b0;
        end else if (start) begin
            active_reg   <= 1'b1;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= BIT_MSB;
            shreg_reg    <= addr[ADDR_W-2:0];
            sreg_clk_reg <= 1'b0;
            sreg_si_reg  <= addr[ADDR_W-1];
        end else if (active_reg) begin
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_reg <= '0;
                if (!sreg_clk_reg) begin
                    sreg_clk_reg <= 1'b1;
                end else begin
                    sreg_clk_reg <= 1'b0;
                    if (bit_cnt_reg == '0) begin
                        active_reg <= 1'b0;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg - 1'b1;
                        sreg_si_reg <= shreg_reg[ADDR_W-2];
                        shreg_reg   <= {shreg_reg[ADDR_W-3:0], 1'b0};
                    end
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/avr_sram_master.sv
// ---------------------------------------------------------------------------
// avr_sram_master
// Host-side initiator for the CPLD SRAM bridge. Accepts one read/write request
// at a time, shifts the address to the bridge (skipped when it equals the last
// address shifted), then sequences ce_n / oe_n / we_n and drives or samples
// the shared data bus. All outputs are registered.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/ready/write/addr/wdata : request handshake (accepted in IDLE)
//   rsp_valid, rsp_rdata          : completion pulse, last read data
//   busy                          : high whenever not IDLE
//   sreg_clk, sreg_si             : serial address to the bridge
//   sram_ce_n/oe_n/we_n           : active-low SRAM strobes
//   data_out, data_oe, data_in    : shared bus drive value, enable, sample
// ---------------------------------------------------------------------------
module avr_sram_master
    import avr_sram_master_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CLK_DIV    = 2,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sreg_clk,
    output logic              sreg_si,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in
);

    localparam int SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYC - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              write_reg;
    logic [ADDR_W-1:0] cache_addr_reg;
    logic              cache_valid_reg;
    logic [SW-1:0]     strobe_cnt_reg;

    logic              req_ready_reg;
    logic              busy_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              ce_n_reg;
    logic              oe_n_reg;
    logic              we_n_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              data_oe_reg;

    logic accept;
    logic cache_hit;
    logic ser_start;
    logic ser_half_end;
    logic ser_done;

    assign accept    = req_valid && req_ready_reg;
    // The bridge still holds the last shifted address, so a repeat skips the shift.
    assign cache_hit = cache_valid_reg && (req_addr == cache_addr_reg);
    assign ser_start = accept && !cache_hit;

    avr_addr_serializer #(
        .ADDR_W  (ADDR_W),
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .start    (ser_start),
        .addr     (req_addr),
        .half_end (ser_half_end),
        .done     (ser_done),
        .sreg_clk (sreg_clk),
        .sreg_si  (sreg_si)
    );

    assign req_ready = req_ready_reg;
    assign busy      = busy_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign sram_ce_n = ce_n_reg;
    assign sram_oe_n = oe_n_reg;
    assign sram_we_n = we_n_reg;
    assign data_out  = data_out_reg;
    assign data_oe   = data_oe_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            write_reg       <= 1'b0;
            cache_addr_reg  <= '0;
            cache_valid_reg <= 1'b0;
            strobe_cnt_reg  <= '0;
            req_ready_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            ce_n_reg        <= 1'b1;
            oe_n_reg        <= 1'b1;
            we_n_reg        <= 1'b1;
            data_out_reg    <= '0;
            data_oe_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        write_reg     <= req_write;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (cache_hit) begin
                            // Enter SETUP directly: its outputs take effect now.
                            state_reg <= ST_SETUP;
                            ce_n_reg  <= 1'b0;
                            if (req_write) begin
                                data_oe_reg  <= 1'b1;
                                data_out_reg <= req_wdata;
                            end
                        end else begin
                            state_reg <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_SHIFT_LO: begin
                    if (ser_half_end)
                        state_reg <= ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    if (ser_done) begin
                        state_reg       <= ST_SETUP;
                        cache_addr_reg  <= addr_reg;
                        cache_valid_reg <= 1'b1;
                        ce_n_reg        <= 1'b0;
                        if (write_reg) begin
                            data_oe_reg  <= 1'b1;
                            data_out_reg <= wdata_reg;
                        end
                    end else if (ser_half_end) begin
                        state_reg <= ST_SHIFT_LO;
                    end
                end
                ST_SETUP: begin
                    state_reg      <= ST_STROBE;
                    strobe_cnt_reg <= '0;
                    if (write_reg)
                        we_n_reg <= 1'b0;
                    else
                        oe_n_reg <= 1'b0;
                end
                ST_STROBE: begin
                    if (strobe_cnt_reg == STROBE_LAST) begin
                        state_reg     <= ST_HOLD;
                        oe_n_reg      <= 1'b1;
                        we_n_reg      <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        if (!write_reg)
                            rsp_rdata_reg <= data_in;
                    end else begin
                        strobe_cnt_reg <= strobe_cnt_reg + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // ce_n and data_oe are held through HOLD for bus hold time.
                    state_reg     <= ST_IDLE;
                    rsp_valid_reg <= 1'b0;
                    ce_n_reg      <= 1'b1;
                    data_oe_reg   <= 1'b0;
                    req_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
